// File: rtl/divergence_display_if.sv
// Bus between the random-word source / board pins and the divergence display.
// The master side drives start/random; the display drives segments and status.
interface divergence_display_if;
   logic        start;
   logic [31:0] random;
   logic [7:0]  seg;
   logic [7:0]  an;
   logic        busy;
   logic        done;
   logic [31:0] value;

   modport master (output start, random, input seg, an, busy, done, value);
   modport slave  (input start, random, output seg, an, busy, done, value);
endinterface

// File: rtl/divergence_display.sv
// Nixie-roll animation of a 32-bit digit word plus an 8-digit multiplexed
// common-anode seven-segment driver.
module divergence_display #(
   parameter logic [15:0] SCAN_DIV    = 16'd5000,
   parameter logic [23:0] FRAME_DIV   = 24'd2_500_000,
   parameter logic [7:0]  ROLL_FRAMES = 8'd20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   divergence_display_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ROLL, SETTLE} state_t;

   state_t      state_q, state_d;
   logic [23:0] frame_q, frame_d;
   logic [7:0]  roll_q, roll_d;
   logic [7:0]  lock_q, lock_d;
   logic [31:0] value_q, value_d;
   logic        done_q, done_d;
   logic [15:0] scan_q, scan_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  seg_q, an_q;
   logic        tick;

   assign tick = (frame_q == FRAME_DIV - 24'd1);

   function automatic logic [7:0] decode(input logic [3:0] code);
      logic [7:0] s;
      case (code)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hE: s = 8'h79;
         4'hF: s = 8'h40;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      roll_d  = roll_q;
      lock_d  = lock_q;
      value_d = value_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ROLL;
               frame_d = '0;
               roll_d  = '0;
               lock_d  = '0;
            end
         end
         ROLL: begin
            frame_d = tick ? '0 : frame_q + 24'd1;
            if (tick) begin
               value_d = bus.random;
               roll_d  = roll_q + 8'd1;
               if (roll_q + 8'd1 == ROLL_FRAMES) state_d = SETTLE;
            end
         end
         SETTLE: begin
            frame_d = tick ? '0 : frame_q + 24'd1;
            if (tick) begin
               lock_d = {1'b1, lock_q[7:1]};
               // digits locked on earlier ticks hold; the one locking now still samples
               for (int k = 0; k < 8; k++)
                  if (!lock_q[k]) value_d[4*k +: 4] = bus.random[4*k +: 4];
               if (lock_d == 8'hFF) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      scan_d = (scan_q == SCAN_DIV - 16'd1) ? '0 : scan_q + 16'd1;
      idx_d  = (scan_q == SCAN_DIV - 16'd1) ? idx_q + 3'd1 : idx_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         frame_q <= '0;
         roll_q  <= '0;
         lock_q  <= '0;
         value_q <= 32'hAAAA_AAAA;
         done_q  <= 1'b0;
         scan_q  <= '0;
         idx_q   <= '0;
         seg_q   <= 8'hFF;
         an_q    <= 8'hFE;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         roll_q  <= roll_d;
         lock_q  <= lock_d;
         value_q <= value_d;
         done_q  <= done_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         // seg and an both load from next-state so the digit and its pattern switch together
         seg_q   <= decode(value_d[{idx_d, 2'b00} +: 4]);
         an_q    <= ~(8'b1 << idx_d);
      end
   end

   assign bus.seg   = seg_q;
   assign bus.an    = an_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.done  = done_q;
   assign bus.value = value_q;
endmodule

// File: tb/tb_divergence_display.sv
// Randomized bench for divergence_display: a time-based model of the animation
// and scan is compared against the DUT every cycle, plus literal spot checks.
module tb_divergence_display;
   localparam int S = 4;
   localparam int F = 8;
   localparam int R = 3;

   logic clk, rst_n;
   divergence_display_if dif ();

   divergence_display #(.SCAN_DIV(16'(S)), .FRAME_DIV(24'(F)), .ROLL_FRAMES(8'(R))) dut (
      .clk(clk), .rst_n(rst_n), .bus(dif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [7:0] DEC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h79, 8'h40};

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Model: elapsed cycles since start decide which frame tick we are on.
   bit          busy_m, done_m;
   logic [31:0] val_m;
   int          t_m, idx_m, sc_m, k_m, s_m;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_m = 0; done_m = 0; val_m = 32'hAAAA_AAAA;
         t_m = 0; idx_m = 0; sc_m = 0;
      end else begin
         done_m = 0;
         if (busy_m) begin
            t_m++;
            if (t_m % F == 0) begin
               k_m = t_m / F;
               if (k_m <= R) val_m = dif.random;
               else begin
                  s_m = k_m - R;
                  for (int n = 0; n < 8; n++)
                     if (n <= 8 - s_m) val_m[4*n +: 4] = dif.random[4*n +: 4];
                  if (s_m == 8) begin busy_m = 0; done_m = 1; end
               end
            end
         end else if (dif.start) begin
            busy_m = 1; t_m = 0;
         end
         sc_m++;
         if (sc_m == S) begin sc_m = 0; idx_m = (idx_m + 1) % 8; end
      end
   end

   logic [7:0] an_e, seg_e;
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         an_e  = ~(8'b1 << idx_m);
         seg_e = DEC[val_m[4*idx_m +: 4]];
         check("value", dif.value, val_m);
         check("busy", 32'(dif.busy), 32'(busy_m));
         check("done", 32'(dif.done), 32'(done_m));
         check("an", 32'(dif.an), 32'(an_e));
         check("seg", 32'(dif.seg), 32'(seg_e));
      end
   end

   task automatic run(input bit hold, input logic [31:0] hv, input bit dbl,
                      output int bcyc, output int dcnt, output int dcyc);
      bcyc = 0; dcnt = 0; dcyc = -1;
      @(negedge clk);
      dif.start = 1'b1;
      dif.random = hold ? hv : $urandom;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         dif.start = dbl && (c == 10 || c == 50);
         if (!hold) dif.random = $urandom;
         if (dif.busy) bcyc++;
         if (dif.done) begin dcnt++; dcyc = c; end
      end
   endtask

   task automatic wait_an(input logic [7:0] a);
      int n;
      n = 0;
      while (dif.an !== a && n < 40) begin @(negedge clk); n++; end
      if (dif.an !== a) check("an_wait", 32'(dif.an), 32'(a));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_seg"}, 32'(dif.seg), 32'h0000_00FF);
      check({tag, "_an"}, 32'(dif.an), 32'h0000_00FE);
      check({tag, "_value"}, dif.value, 32'hAAAA_AAAA);
      check({tag, "_busy"}, 32'(dif.busy), 32'h0);
      check({tag, "_done"}, 32'(dif.done), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   int bc, dc, dy;
   logic [7:0] ae;

   initial begin
      rst_n = 1'b1; dif.start = 1'b0; dif.random = 32'h0;
      #3 rst_n = 1'b0;
      #1 check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Scan steps every S clocks through all eight digits and wraps.
      for (int s = 0; s < 9; s++)
         for (int j = 0; j < S; j++) begin
            if (!(s == 0 && j == 0)) @(negedge clk);
            ae = ~(8'b1 << (s % 8));
            check("an_step", 32'(dif.an), 32'(ae));
         end

      run(1'b1, 32'hF123_4567, 1'b0, bc, dc, dy);
      check("full_busy_cycles", bc, 88);
      check("full_done_count", dc, 1);
      check("full_done_cycle", dy, 88);
      check("full_value", dif.value, 32'hF123_4567);
      wait_an(8'h7F);
      check("full_seg_idx7", 32'(dif.seg), 32'h40);
      wait_an(8'hFE);
      check("full_seg_idx0", 32'(dif.seg), 32'hF8);

      for (int r = 0; r < 3; r++) begin
         run(1'b0, 32'h0, 1'b0, bc, dc, dy);
         check("rand_done_cycle", dy, 88);
      end

      run(1'b0, 32'h0, 1'b1, bc, dc, dy);
      check("ign_busy_cycles", bc, 88);
      check("ign_done_count", dc, 1);
      check("ign_done_cycle", dy, 88);

      // Mid-run reset during SETTLE: no done, reset values appear at once.
      dc = 0;
      @(negedge clk);
      dif.start = 1'b1;
      for (int c = 0; c < 44; c++) begin
         @(negedge clk);
         dif.start = 1'b0;
         dif.random = $urandom;
         if (dif.done) dc++;
      end
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      check("midrst_no_done", dc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(1'b0, 32'h0, 1'b0, bc, dc, dy);
      check("rerun_busy_cycles", bc, 88);
      check("rerun_done_count", dc, 1);

      for (int code = 0; code < 16; code++) begin
         run(1'b1, {4'hF, 24'h0, 4'(code)}, 1'b0, bc, dc, dy);
         wait_an(8'hFE);
         check("decode_sweep", 32'(dif.seg), 32'(DEC[code]));
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
